// File: rtl/custom_write.sv
// Packs a stream of pulse-width samples MSB-first into RAM words and writes one frame
// of N_WORDS words from BASE_ADDR; a flush closes the frame early with zero padding.
`timescale 1ns/1ps
module custom_write #(
  parameter int unsigned        W_ADDR    = 12,
  parameter int unsigned        W_DATA    = 128,
  parameter int unsigned        W_PW      = 16,
  parameter logic [W_ADDR-1:0]  BASE_ADDR = '0,
  parameter int unsigned        N_WORDS   = 4
) (
  input  logic              clk,
  input  logic              custom_rst,
  input  logic              custom_en,
  input  logic              flush,
  input  logic [W_PW-1:0]   pw_data,
  input  logic              pw_valid,
  output logic              pw_ready,
  output logic [W_ADDR-1:0] custom_wr_addr,
  output logic [W_DATA-1:0] custom_wr_data,
  output logic              custom_wren_b,
  output logic              busy,
  output logic              done,
  output logic [W_ADDR-1:0] word_cnt
);

  localparam int unsigned LANES  = W_DATA / W_PW;
  localparam int unsigned W_LANE = $clog2(LANES + 1);
  localparam int unsigned W_CNT  = W_ADDR + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [W_LANE-1:0]   lane_q, lane_d, lane_n;
  logic [W_DATA-1:0]   pack_q, pack_d, pack_beat;
  logic [W_ADDR-1:0]   ptr_q, ptr_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                flush_pend_q, flush_pend_d;
  logic                wren_q, wren_d;
  logic [W_ADDR-1:0]   wr_addr_q, wr_addr_d;
  logic [W_DATA-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                beat;
  int unsigned         pad_bits;

  assign pw_ready       = (state_q == S_FILL);
  assign custom_wren_b  = wren_q;
  assign custom_wr_addr = wr_addr_q;
  assign custom_wr_data = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign word_cnt       = cnt_q[W_ADDR-1:0];

  // Next-state, packing and registered-output staging
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    beat      = pw_valid && (state_q == S_FILL);
    lane_n    = lane_q + W_LANE'(beat);
    pack_beat = beat ? {pack_q[W_DATA-W_PW-1:0], pw_data} : pack_q;
    pad_bits  = (LANES - 32'(lane_n)) * W_PW;
    cnt_inc   = cnt_q + W_CNT'(1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (custom_en) begin
          state_d      = S_FILL;
          ptr_d        = BASE_ADDR;
          cnt_d        = '0;
          lane_d       = '0;
          pack_d       = '0;
          flush_pend_d = 1'b0;
        end
      end
      S_FILL: begin
        if (beat) begin
          pack_d = pack_beat;
          lane_d = lane_n;
        end
        if (beat && (lane_q == W_LANE'(LANES - 1))) begin
          state_d      = S_WRITE;
          flush_pend_d = flush;
        end else if (flush && (lane_n != '0)) begin
          // Left-justify the partial word; unused low lanes become zero
          state_d      = S_WRITE;
          pack_d       = pack_beat << pad_bits;
          flush_pend_d = 1'b1;
        end else if (flush) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        ptr_d        = ptr_q + W_ADDR'(1);
        cnt_d        = cnt_inc;
        lane_d       = '0;
        pack_d       = '0;
        flush_pend_d = 1'b0;
        if ((cnt_inc >= W_CNT'(N_WORDS)) || flush_pend_q || flush) state_d = S_DONE;
        else                                                         state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase

    wren_d    = (state_d == S_WRITE);
    wr_addr_d = (state_d == S_WRITE) ? ptr_q  : wr_addr_q;
    wr_data_d = (state_d == S_WRITE) ? pack_d : wr_data_q;
    busy_d    = (state_d == S_FILL) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (custom_rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      pack_q       <= '0;
      ptr_q        <= BASE_ADDR;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      wren_q       <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      wren_q       <= wren_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_custom_write.sv
// Scoreboard bench for custom_write: two instances (BASE_ADDR 0 and 12'hFFE) share one
// stimulus driver selected by `sel`; expected writes come from a bench-side packing model.
`timescale 1ns/1ps
module tb_custom_write;

  typedef struct packed {
    logic [11:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, flush, pw_valid, sel;
  logic [15:0] pw_data;

  logic        rdy_a, wren_a, busy_a, done_a;
  logic [11:0] addr_a, wc_a;
  logic [127:0] data_a;
  logic        rdy_b, wren_b, busy_b, done_b;
  logic [11:0] addr_b, wc_b;
  logic [127:0] data_b;

  custom_write #(.BASE_ADDR(12'h000)) u_dut_a (
    .clk(clk), .custom_rst(rst), .custom_en(en & ~sel), .flush(flush & ~sel),
    .pw_data(pw_data), .pw_valid(pw_valid & ~sel), .pw_ready(rdy_a),
    .custom_wr_addr(addr_a), .custom_wr_data(data_a), .custom_wren_b(wren_a),
    .busy(busy_a), .done(done_a), .word_cnt(wc_a));

  custom_write #(.BASE_ADDR(12'hFFE)) u_dut_b (
    .clk(clk), .custom_rst(rst), .custom_en(en & sel), .flush(flush & sel),
    .pw_data(pw_data), .pw_valid(pw_valid & sel), .pw_ready(rdy_b),
    .custom_wr_addr(addr_b), .custom_wr_data(data_b), .custom_wren_b(wren_b),
    .busy(busy_b), .done(done_b), .word_cnt(wc_b));

  logic        rdy_s, wren_s, wren_o, busy_s, done_s;
  logic [11:0] addr_s, wc_s;
  logic [127:0] data_s;
  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign wren_s = sel ? wren_b : wren_a;
  assign wren_o = sel ? wren_a : wren_b;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign addr_s = sel ? addr_b : addr_a;
  assign wc_s   = sel ? wc_b   : wc_a;
  assign data_s = sel ? data_b : data_a;

  wr_t sb[$];
  wr_t wlog[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic [11:0]  m_ptr;
  logic [127:0] m_pack;
  int           m_lane, m_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [127:0] d);
    wr_t e;
    e.addr = m_ptr;
    e.data = d;
    sb.push_back(e);
    m_ptr++;
    m_cnt++;
    m_lane = 0;
  endtask

  task automatic model_beat(input logic [15:0] d, input bit fl);
    m_pack = {m_pack[111:0], d};
    m_lane++;
    if (m_lane == 8)  push_word(m_pack);
    else if (fl)      push_word(m_pack << ((8 - m_lane) * 16));
  endtask

  // Write monitor: every DUT write is popped against the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (wren_s) begin
      e.addr = addr_s;
      e.data = data_s;
      wlog.push_back(e);
      check("ready_in_write", 128'(rdy_s), 128'(0));
      check("other_wren", 128'(wren_o), 128'(0));
      if (sb.size() == 0) begin
        check("unexpected_write", 128'(wren_s), 128'(0));
      end else begin
        e = sb.pop_front();
        check("wr_addr", 128'(addr_s), 128'(e.addr));
        check("wr_data", data_s, e.data);
      end
    end
  end

  task automatic start(input bit s);
    sel    = s;
    en     = 1'b1;
    m_ptr  = s ? 12'hFFE : 12'h000;
    m_pack = '0;
    m_lane = 0;
    m_cnt  = 0;
    wlog.delete();
    @(negedge clk);
    en = 1'b0;
    check("busy_after_start", 128'(busy_s), 128'(1));
  endtask

  // Called at a negedge; leaves pw_valid high so calls chain back-to-back
  task automatic send(input logic [15:0] d, input bit gaps, input bit fl);
    int n = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1 && n < 4) begin
        pw_valid = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    pw_data  = d;
    pw_valid = 1'b1;
    n = 0;
    while (!rdy_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_s) begin
      check("ready_timeout", 128'(rdy_s), 128'(1));
      pw_valid = 1'b0;
      return;
    end
    flush = fl;
    model_beat(d, fl);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    pw_valid = 1'b0;
    while (!rdy_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("flush_ready", 128'(rdy_s), 128'(1));
    flush = 1'b1;
    if (m_lane > 0) push_word(m_pack << ((8 - m_lane) * 16));
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    pw_valid = 1'b0;
    while (!done_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_done"}, 128'(done_s), 128'(1));
    check({tag, "_busy"}, 128'(busy_s), 128'(0));
    check({tag, "_word_cnt"}, 128'(wc_s), 128'(m_cnt));
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  task automatic stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) send(16'(i), gaps, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; pw_valid = 1'b0; pw_data = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(rdy_a), 128'(0));
    check("rst_wren", 128'(wren_a), 128'(0));
    check("rst_addr_a", 128'(addr_a), 128'(12'h000));
    check("rst_addr_b", 128'(addr_b), 128'(12'hFFE));
    check("rst_data", data_a, 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_done", 128'(done_a), 128'(0));
    check("rst_word_cnt", 128'(wc_a), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Full frame, back-to-back samples
    start(1'b0);
    stream(32, 1'b0);
    wait_done("t1");
    check("t1_nwrites", 128'(wlog.size()), 128'(4));
    check("t1_word0", wlog[0].data, 128'h0000_0001_0002_0003_0004_0005_0006_0007);

    // Same frame with pw_valid gaps
    start(1'b0);
    stream(32, 1'b1);
    wait_done("t2");
    check("t2_nwrites", 128'(wlog.size()), 128'(4));
    check("t2_addr3", 128'(wlog[3].addr), 128'(12'h003));

    // Partial word flushed, zero-padded
    start(1'b0);
    send(16'h000A, 1'b0, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b0, 1'b0);
    do_flush();
    wait_done("t3");
    check("t3_nwrites", 128'(wlog.size()), 128'(1));
    check("t3_data", wlog[0].data, 128'h000A_000B_000C_0000_0000_0000_0000_0000);

    // Flush at lane 0 after one full word: no extra write
    start(1'b0);
    stream(8, 1'b0);
    do_flush();
    wait_done("t4a");
    check("t4a_nwrites", 128'(wlog.size()), 128'(1));

    // Flush together with the eighth beat: exactly one write
    start(1'b0);
    stream(7, 1'b0);
    send(16'h0007, 1'b0, 1'b1);
    wait_done("t4b");
    check("t4b_nwrites", 128'(wlog.size()), 128'(1));

    // Reset mid-word discards the partial word
    start(1'b0);
    stream(5, 1'b0);
    pw_valid = 1'b0;
    rst = 1'b1;
    m_lane = 0;
    @(negedge clk);
    rst = 1'b0;
    check("t5_wren", 128'(wren_a), 128'(0));
    check("t5_addr", 128'(addr_a), 128'(12'h000));
    check("t5_data", data_a, 128'(0));
    check("t5_busy", 128'(busy_a), 128'(0));
    check("t5_done", 128'(done_a), 128'(0));
    check("t5_word_cnt", 128'(wc_a), 128'(0));
    check("t5_ready", 128'(rdy_a), 128'(0));
    repeat (5) @(negedge clk);
    check("t5_no_write", 128'(wlog.size()), 128'(0));
    start(1'b0);
    stream(32, 1'b0);
    wait_done("t5r");
    check("t5r_addr0", 128'(wlog[0].addr), 128'(12'h000));

    // Address wrap from BASE_ADDR 12'hFFE
    start(1'b1);
    stream(32, 1'b0);
    wait_done("t6");
    check("t6_nwrites", 128'(wlog.size()), 128'(4));
    check("t6_addr0", 128'(wlog[0].addr), 128'(12'hFFE));
    check("t6_addr1", 128'(wlog[1].addr), 128'(12'hFFF));
    check("t6_addr2", 128'(wlog[2].addr), 128'(12'h000));
    check("t6_addr3", 128'(wlog[3].addr), 128'(12'h001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
